// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and write-back source codes.
// Imported by the MEM/WB stage and its result selector.
package core_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] RES_SRC_ALU = 2'b00;
    localparam logic [1:0] RES_SRC_MEM = 2'b01;
    localparam logic [1:0] RES_SRC_PC4 = 2'b10;

endpackage

// File: rtl/wb_result_mux.sv
// Write-back result selector: 4:1 combinational mux on a 2-bit select.
// Any code outside the three defined sources falls back to in3.
module wb_result_mux
    import core_pkg::*;
#(
    parameter int WIDTH = XLEN_DEF
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] y
);

    // Pick the source named by sel; reserved code takes in3.
    always_comb begin
        y = in3;
        case (sel)
            RES_SRC_ALU: y = in0;
            RES_SRC_MEM: y = in1;
            RES_SRC_PC4: y = in2;
            default:     y = in3;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with stall/flush, plus write-back selection.
// Drives the register-file write port from the latched fields.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [XLEN-1:0]   pc_plus_4_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [XLEN-1:0]   read_data_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              reg_write_in,
    input  logic [1:0]        result_src_in,
    output logic [XLEN-1:0]   pc_plus_4_out,
    output logic [XLEN-1:0]   alu_result_out,
    output logic [XLEN-1:0]   read_data_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              reg_write_out,
    output logic [1:0]        result_src_out,
    output logic [XLEN-1:0]   write_back_data,
    output logic              wb_we
);

    // Pipeline latch: reset > flush (bubble) > stall (hold) > capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_plus_4_out  <= '0;
            alu_result_out <= '0;
            read_data_out  <= '0;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            result_src_out <= '0;
        end else if (flush) begin
            pc_plus_4_out  <= '0;
            alu_result_out <= '0;
            read_data_out  <= '0;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            result_src_out <= '0;
        end else if (!stall) begin
            pc_plus_4_out  <= pc_plus_4_in;
            alu_result_out <= alu_result_in;
            read_data_out  <= read_data_in;
            rd_out         <= rd_in;
            reg_write_out  <= reg_write_in;
            result_src_out <= result_src_in;
        end
    end

    wb_result_mux #(
        .WIDTH (XLEN)
    ) u_wb_mux (
        .sel (result_src_out),
        .in0 (alu_result_out),
        .in1 (read_data_out),
        .in2 (pc_plus_4_out),
        .in3 (alu_result_out),
        .y   (write_back_data)
    );

    // x0 is hardwired to zero, so never strobe a write to it.
    assign wb_we = reg_write_out && (rd_out != '0);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed cases then random traffic.
// A behavioural model tracks the expected latched state and result.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] pc_plus_4_in;
    logic [31:0] alu_result_in;
    logic [31:0] read_data_in;
    logic [4:0]  rd_in;
    logic        reg_write_in;
    logic [1:0]  result_src_in;
    logic [31:0] pc_plus_4_out;
    logic [31:0] alu_result_out;
    logic [31:0] read_data_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic [1:0]  result_src_out;
    logic [31:0] write_back_data;
    logic        wb_we;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_alu;
    logic [31:0] m_rdata;
    logic [4:0]  m_rd;
    logic        m_we;
    logic [1:0]  m_src;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .pc_plus_4_in    (pc_plus_4_in),
        .alu_result_in   (alu_result_in),
        .read_data_in    (read_data_in),
        .rd_in           (rd_in),
        .reg_write_in    (reg_write_in),
        .result_src_in   (result_src_in),
        .pc_plus_4_out   (pc_plus_4_out),
        .alu_result_out  (alu_result_out),
        .read_data_out   (read_data_out),
        .rd_out          (rd_out),
        .reg_write_out   (reg_write_out),
        .result_src_out  (result_src_out),
        .write_back_data (write_back_data),
        .wb_we           (wb_we)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_wb();
        if (m_src == 2'd1) return m_rdata;
        if (m_src == 2'd2) return m_pc;
        return m_alu;
    endfunction

    task automatic model_clear();
        m_pc = 0; m_alu = 0; m_rdata = 0;
        m_rd = 0; m_we = 0; m_src = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc_plus_4_out, m_pc);
        check({tag, ".alu"}, alu_result_out, m_alu);
        check({tag, ".rdata"}, read_data_out, m_rdata);
        check({tag, ".rd"}, {27'd0, rd_out}, {27'd0, m_rd});
        check({tag, ".we_l"}, {31'd0, reg_write_out}, {31'd0, m_we});
        check({tag, ".src"}, {30'd0, result_src_out}, {30'd0, m_src});
        check({tag, ".wbd"}, write_back_data, model_wb());
        check({tag, ".wb_we"}, {31'd0, wb_we},
              {31'd0, (m_we && m_rd != 0)});
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] rdata, input logic [4:0] rd,
                          input logic we, input logic [1:0] src);
        pc_plus_4_in  = pc;
        alu_result_in = alu;
        read_data_in  = rdata;
        rd_in         = rd;
        reg_write_in  = we;
        result_src_in = src;
    endtask

    task automatic rand_in();
        set_in($urandom, $urandom, $urandom, 5'($urandom),
               1'($urandom), 2'($urandom));
    endtask

    // Advance one edge, updating the model from the spec rules.
    task automatic tick();
        if (flush) begin
            model_clear();
        end else if (!stall) begin
            m_pc = pc_plus_4_in; m_alu = alu_result_in;
            m_rdata = read_data_in; m_rd = rd_in;
            m_we = reg_write_in; m_src = result_src_in;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        model_clear();
        rand_in();
        #2;
        check_all("reset");
        check("reset.wbd0", write_back_data, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        set_in(32'h4, 32'hA5A5A5A5, 32'h12345678, 5'd10, 1'b1, 2'b00);
        tick();
        check_all("alu");
        check("alu.wbd", write_back_data, 32'hA5A5A5A5);

        set_in(32'h8, 32'hCAFEBABE, 32'h87654321, 5'd11, 1'b1, 2'b01);
        #1;
        check("mem.pre", write_back_data, 32'hA5A5A5A5);
        tick();
        check_all("mem");
        check("mem.wbd", write_back_data, 32'h87654321);

        set_in(32'h100, 32'h1, 32'h2, 5'd0, 1'b1, 2'b10);
        tick();
        check_all("pc4x0");
        check("pc4x0.we", {31'd0, wb_we}, 32'd0);
        set_in(32'h100, 32'h1, 32'h2, 5'd5, 1'b1, 2'b10);
        tick();
        check_all("pc4");
        check("pc4.we", {31'd0, wb_we}, 32'd1);

        set_in(32'h4, 32'hA5A5A5A5, 32'h12345678, 5'd10, 1'b1, 2'b00);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_in();
            tick();
            check_all("stall");
            check("stall.wbd", write_back_data, 32'hA5A5A5A5);
        end
        flush = 1'b1;
        tick();
        check_all("flush");
        check("flush.wbd", write_back_data, 32'h0);
        stall = 1'b0; flush = 1'b0;

        set_in(32'hC, 32'h5, 32'h87654321, 5'd7, 1'b1, 2'b01);
        tick();
        check("arst.pre", write_back_data, 32'h87654321);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_all("arst");
        @(posedge clk);
        #1;
        check_all("arst.hold");
        reset = 1'b0;
        set_in(32'h20, 32'h33, 32'h44, 5'd3, 1'b1, 2'b01);
        tick();
        check_all("arst.rel");
        check("arst.relwbd", write_back_data, 32'h44);

        for (int i = 0; i < 300; i++) begin
            rand_in();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                #1;
                model_clear();
                check_all("rnd.rst");
                reset = 1'b0;
            end
            tick();
            check_all("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Pipeline MEM/WB boundary register of the 5-stage RV32 core, combined with the write-back result selector.
- Captures the MEM-stage results on each rising clock edge: PC+4, ALU result, load data, rd and control.
- Drives the register-file write port (data, address, enable) from the latched values.
- Supports stall (hold) and flush (bubble insert).

Parameters:
XLEN, 32, datapath width in bits
REG_AW, 5, register-file address width

Ports:
clk  in  1  pipeline clock, rising-edge active
reset  in  1  asynchronous, active-high; clears all state
stall  in  1  hold current contents (no capture)
flush  in  1  load a bubble on next edge
pc_plus_4_in  in  XLEN  PC+4 of the MEM-stage instruction
alu_result_in  in  XLEN  ALU result from MEM stage
read_data_in  in  XLEN  data-memory load data
rd_in  in  REG_AW  destination register index
reg_write_in  in  1  register write enable from MEM stage
result_src_in  in  2  write-back source select
pc_plus_4_out  out  XLEN  latched PC+4
alu_result_out  out  XLEN  latched ALU result
read_data_out  out  XLEN  latched load data
rd_out  out  REG_AW  latched rd
reg_write_out  out  1  latched write enable
result_src_out  out  2  latched select
write_back_data  out  XLEN  selected write-back value (combinational from latched fields)
wb_we  out  1  register-file write strobe

Behaviour:
Register update priority: reset > flush > stall > capture.
- reset = 1: asynchronously force every latched field to 0, independent of clk. The register-file write strobe (wb_we) is therefore 0, and write_back_data is 0.
- flush = 1 on a rising edge: load all fields with 0, i.e. a bubble.
- stall = 1 on a rising edge, flush = 0: all fields keep their value.
- Otherwise: on each rising edge, each *_out takes the corresponding *_in. Latency is exactly 1 cycle.

write_back_data is purely combinational from the latched fields; no extra cycle. Selection by result_src_out:
- 2'b00: alu_result_out
- 2'b01: read_data_out
- 2'b10: pc_plus_4_out (JAL/JALR)
- 2'b11: alu_result_out (reserved, defined default)

wb_we = reg_write_out AND (rd_out != 0). Register x0 is never written.

Boundary conditions:
- Reset asserted mid-cycle: outputs go to 0 immediately.
- Reset deasserted: the first capture happens at the next rising edge.
- flush and stall both high: flush wins.
- No arithmetic; all values pass through unmodified at full width.

Decomposition:
- Shared package (core_pkg): localparams RES_SRC_ALU = 2'b00, RES_SRC_MEM = 2'b01, RES_SRC_PC4 = 2'b10; XLEN and REG_AW defaults.
- One natural sub-module: wb_result_mux, a parameterized 4:1 combinational selector (WIDTH, 2-bit sel, default branch). It is instantiated once for write_back_data.
- The latch itself stays in mem_wb_stage as a single always block with asynchronous reset.

Test Plan:
1. Reset: assert reset with arbitrary inputs, no clock edge -> all outputs 0, write_back_data = 0x00000000, wb_we = 0.
2. ALU path: pc_plus_4_in = 0x4, alu_result_in = 0xA5A5A5A5, read_data_in = 0x12345678, rd_in = 10, reg_write_in = 1, src = 00, then one edge -> write_back_data = 0xA5A5A5A5, rd_out = 10, wb_we = 1.
3. MEM path: alu_result_in = 0xCAFEBABE, read_data_in = 0x87654321, rd_in = 11, src = 01, then one edge -> write_back_data = 0x87654321, rd_out = 11. Also check that before the edge the previous value 0xA5A5A5A5 is still shown.
4. PC+4 path and x0 guard:
   - pc_plus_4_in = 0x100, src = 10, rd_in = 0, reg_write_in = 1, edge -> write_back_data = 0x100, wb_we = 0.
   - Same with rd_in = 5 -> wb_we = 1.
5. Stall/flush:
   - After loading 0xA5A5A5A5, hold stall = 1 for 2 edges while the inputs change -> outputs unchanged.
   - Then flush = 1 and stall = 1 on one edge -> all outputs 0.
6. Async reset mid-operation: with the stage loaded with 0x87654321, raise reset between clock edges -> write_back_data = 0 before the next edge. After release, the first edge captures the inputs again.
